// File: rtl/d_mem_arbiter.sv
// d_mem_arbiter: shares one data-memory port between the core load/store
// unit (C) and the external/debug port (E). Contested cycles use a weighted
// round-robin that gives C up to CORE_WEIGHT consecutive grants and then
// hands one grant to E. Addresses are checked against the data-memory window
// and rebased to a memory offset. Read data comes back one cycle later and is
// routed to whichever port issued the load.
module d_mem_arbiter #(
    parameter logic [31:0] D_MEM_OFFSET = 32'h0000_1000,
    parameter logic [31:0] D_MEM_SIZE   = 32'h0000_1000,
    parameter int unsigned CORE_WEIGHT  = 3
) (
    input  logic        Clk,
    input  logic        Rst,
    // core port
    input  logic        CReq,
    input  logic        CWrEn,
    input  logic [31:0] CAddr,
    input  logic [31:0] CWrData,
    input  logic [3:0]  CByteEn,
    output logic        CGnt,
    output logic        CRdValid,
    output logic [31:0] CRdData,
    output logic        CErr,
    // external / debug port
    input  logic        EReq,
    input  logic        EWrEn,
    input  logic [31:0] EAddr,
    input  logic [31:0] EWrData,
    input  logic [3:0]  EByteEn,
    output logic        EGnt,
    output logic        ERdValid,
    output logic [31:0] ERdData,
    output logic        EErr,
    // memory port
    output logic        MemRdEn,
    output logic        MemWrEn,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWrData,
    output logic [3:0]  MemByteEn,
    input  logic [31:0] MemRdData
);

    // End of the window computed one bit wider so a window touching the top
    // of the address space cannot wrap around to zero.
    localparam logic [32:0] WIN_BASE = {1'b0, D_MEM_OFFSET};
    localparam logic [32:0] WIN_END  = {1'b0, D_MEM_OFFSET} + {1'b0, D_MEM_SIZE};
    localparam logic [2:0]  WEIGHT   = 3'(CORE_WEIGHT);

    // Which port the read data arriving this cycle belongs to.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_C    = 2'd1,
        OWN_E    = 2'd2
    } owner_t;

    logic [2:0]  cnt;
    owner_t      rsp_owner;
    logic        c_err;
    logic        e_err;
    logic [31:0] c_rd_hold;
    logic [31:0] e_rd_hold;

    logic        c_gnt;
    logic        e_gnt;
    logic        accepted;
    logic        sel_wr;
    logic [31:0] sel_addr;
    logic [31:0] sel_wr_data;
    logic [3:0]  sel_byte_en;
    logic        in_range;
    logic        mem_hit;
    logic        c_valid;
    logic        e_valid;

    // Same-cycle grant decision; nothing is granted while reset is held.
    always_comb begin
        c_gnt = 1'b0;
        e_gnt = 1'b0;
        if (!Rst) begin
            if (CReq && (!EReq || (cnt < WEIGHT))) begin
                c_gnt = 1'b1;
            end else if (EReq) begin
                e_gnt = 1'b1;
            end
        end
    end

    // Steer the winning port's request onto the shared request path.
    always_comb begin
        sel_wr      = CWrEn;
        sel_addr    = CAddr;
        sel_wr_data = CWrData;
        sel_byte_en = CByteEn;
        if (e_gnt) begin
            sel_wr      = EWrEn;
            sel_addr    = EAddr;
            sel_wr_data = EWrData;
            sel_byte_en = EByteEn;
        end
    end

    assign accepted = c_gnt | e_gnt;
    assign in_range = ({1'b0, sel_addr} >= WIN_BASE) && ({1'b0, sel_addr} < WIN_END);
    assign mem_hit  = accepted & in_range;

    // Memory strobes and payload; payload is zeroed when no access is made so
    // the bus is quiet outside real transfers.
    always_comb begin
        MemRdEn   = 1'b0;
        MemWrEn   = 1'b0;
        MemAddr   = 32'h0;
        MemWrData = 32'h0;
        MemByteEn = 4'h0;
        if (mem_hit) begin
            MemRdEn   = ~sel_wr;
            MemWrEn   = sel_wr;
            MemAddr   = sel_addr - D_MEM_OFFSET;
            MemWrData = sel_wr_data;
            MemByteEn = sel_byte_en;
        end
    end

    // Weight counter: counts contested core grants, restarts whenever E is
    // served or not asking, and saturates at the weight.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt <= 3'd0;
        end else if (e_gnt || !EReq) begin
            cnt <= 3'd0;
        end else if (c_gnt && (cnt < WEIGHT)) begin
            cnt <= cnt + 3'd1;
        end
    end

    // Response owner tag: remembers who issued the load whose data returns
    // next cycle. Reset drops any load still in flight.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rsp_owner <= OWN_NONE;
        end else if (mem_hit && !sel_wr) begin
            rsp_owner <= e_gnt ? OWN_E : OWN_C;
        end else begin
            rsp_owner <= OWN_NONE;
        end
    end

    // Out-of-range rejection pulses, one cycle after the grant.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            c_err <= 1'b0;
            e_err <= 1'b0;
        end else begin
            c_err <= c_gnt & ~in_range;
            e_err <= e_gnt & ~in_range;
        end
    end

    // Capture delivered read data so each port's RdData holds its last value.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            c_rd_hold <= 32'h0;
            e_rd_hold <= 32'h0;
        end else begin
            if (rsp_owner == OWN_C) begin
                c_rd_hold <= MemRdData;
            end
            if (rsp_owner == OWN_E) begin
                e_rd_hold <= MemRdData;
            end
        end
    end

    assign c_valid  = (rsp_owner == OWN_C);
    assign e_valid  = (rsp_owner == OWN_E);

    assign CGnt     = c_gnt;
    assign EGnt     = e_gnt;
    assign CRdValid = c_valid;
    assign ERdValid = e_valid;
    assign CRdData  = c_valid ? MemRdData : c_rd_hold;
    assign ERdData  = e_valid ? MemRdData : e_rd_hold;
    assign CErr     = c_err;
    assign EErr     = e_err;

endmodule

// File: tb/tb_d_mem_arbiter.sv
// tb_d_mem_arbiter: directed bench for d_mem_arbiter with a behavioural
// memory and a read-response scoreboard.
module tb_d_mem_arbiter;

    logic        Clk;
    logic        Rst;
    logic        CReq, CWrEn;
    logic [31:0] CAddr, CWrData;
    logic [3:0]  CByteEn;
    logic        CGnt, CRdValid, CErr;
    logic [31:0] CRdData;
    logic        EReq, EWrEn;
    logic [31:0] EAddr, EWrData;
    logic [3:0]  EByteEn;
    logic        EGnt, ERdValid, EErr;
    logic [31:0] ERdData;
    logic        MemRdEn, MemWrEn;
    logic [31:0] MemAddr, MemWrData;
    logic [3:0]  MemByteEn;
    logic [31:0] MemRdData;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        is_e;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    d_mem_arbiter #(
        .D_MEM_OFFSET(32'h1000),
        .D_MEM_SIZE  (32'h1000),
        .CORE_WEIGHT (3)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .CReq(CReq), .CWrEn(CWrEn), .CAddr(CAddr), .CWrData(CWrData), .CByteEn(CByteEn),
        .CGnt(CGnt), .CRdValid(CRdValid), .CRdData(CRdData), .CErr(CErr),
        .EReq(EReq), .EWrEn(EWrEn), .EAddr(EAddr), .EWrData(EWrData), .EByteEn(EByteEn),
        .EGnt(EGnt), .ERdValid(ERdValid), .ERdData(ERdData), .EErr(EErr),
        .MemRdEn(MemRdEn), .MemWrEn(MemWrEn), .MemAddr(MemAddr), .MemWrData(MemWrData),
        .MemByteEn(MemByteEn), .MemRdData(MemRdData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Contents of the memory as a function of byte offset.
    function automatic logic [31:0] mem_word(input logic [31:0] off);
        return 32'hA500_0000 ^ (off * 32'h0001_0003) ^ 32'h0000_C0DE;
    endfunction

    // Memory model: data one cycle after a read strobe, noise otherwise.
    always @(posedge Clk) begin
        MemRdData <= MemRdEn ? mem_word(MemAddr) : $urandom;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic is_e, input logic [31:0] addr);
        exp_t e;
        e.is_e = is_e;
        e.data = mem_word(addr - 32'h1000);
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        CReq = 1'b0; EReq = 1'b0; CWrEn = 1'b0; EWrEn = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   32'({CGnt, EGnt}), 32'h0);
        check({tag, "_memen"}, 32'({MemRdEn, MemWrEn}), 32'h0);
        check({tag, "_rdv"},   32'({CRdValid, ERdValid}), 32'h0);
        check({tag, "_err"},   32'({CErr, EErr}), 32'h0);
        check({tag, "_crd"},   CRdData, 32'h0);
        check({tag, "_erd"},   ERdData, 32'h0);
        check({tag, "_maddr"}, MemAddr, 32'h0);
        check({tag, "_mwd"},   MemWrData, 32'h0);
        check({tag, "_mbe"},   32'(MemByteEn), 32'h0);
    endtask

    // Scoreboard: every read response is matched against the oldest expectation.
    always @(negedge Clk) begin
        if (!Rst && (CRdValid || ERdValid)) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_rsp", 32'({CRdValid, ERdValid}), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_owner", 32'({CRdValid, ERdValid}), e.is_e ? 32'h1 : 32'h2);
                check("rsp_data", e.is_e ? ERdData : CRdData, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        Rst = 1'b1;
        idle();
        CAddr = 32'h1000; EAddr = 32'h1000;
        CWrData = 32'h0; EWrData = 32'h0; CByteEn = 4'h0; EByteEn = 4'h0;

        // Reset state, with requests pending to show grants are held off.
        CReq = 1'b1; EReq = 1'b1;
        @(negedge Clk);
        check_all_zero("reset");
        step();
        idle();
        Rst = 1'b0;
        step();

        // Test 1: single core load.
        CReq = 1'b1; CWrEn = 1'b0; CAddr = 32'h1004;
        @(negedge Clk);
        check("t1_cgnt", 32'(CGnt), 32'h1);
        check("t1_rden", 32'(MemRdEn), 32'h1);
        check("t1_maddr", MemAddr, 32'h4);
        push(1'b0, 32'h1004);
        step();
        idle();
        @(negedge Clk);
        check("t1_crdv", 32'(CRdValid), 32'h1);
        step();
        @(negedge Clk);
        check("t1_crdv_drop", 32'(CRdValid), 32'h0);
        check("t1_crd_hold", CRdData, mem_word(32'h4));
        step();

        // Test 2: both ports loading every cycle.
        begin
            int ci = 0;
            int ei = 0;
            logic exp_e;
            CReq = 1'b1; EReq = 1'b1; CWrEn = 1'b0; EWrEn = 1'b0;
            for (int k = 0; k < 8; k++) begin
                CAddr = 32'h1100 + 32'(ci) * 32'd4;
                EAddr = 32'h1800 + 32'(ei) * 32'd4;
                @(negedge Clk);
                exp_e = ((k % 4) == 3);
                check("t2_cgnt", 32'(CGnt), 32'(!exp_e));
                check("t2_egnt", 32'(EGnt), 32'(exp_e));
                if (exp_e) begin
                    push(1'b1, EAddr);
                    ei++;
                end else begin
                    push(1'b0, CAddr);
                    ci++;
                end
                step();
            end
            idle();
            step();
        end

        // Test 3: out-of-range store on E, then out-of-range load on C.
        EReq = 1'b1; EWrEn = 1'b1; EAddr = 32'h0FFC; EWrData = 32'h1234_5678; EByteEn = 4'hF;
        @(negedge Clk);
        check("t3_egnt", 32'(EGnt), 32'h1);
        check("t3a_memen", 32'({MemRdEn, MemWrEn}), 32'h0);
        step();
        idle();
        CReq = 1'b1; CAddr = 32'h2000;
        @(negedge Clk);
        check("t3_cgnt", 32'(CGnt), 32'h1);
        check("t3b_memen", 32'({MemRdEn, MemWrEn}), 32'h0);
        check("t3_eerr", 32'({CErr, EErr}), 32'h1);
        step();
        idle();
        @(negedge Clk);
        check("t3_cerr", 32'({CErr, EErr}), 32'h2);
        check("t3_rdv", 32'({CRdValid, ERdValid}), 32'h0);
        step();
        @(negedge Clk);
        check("t3_err_clear", 32'({CErr, EErr}), 32'h0);
        step();

        // Test 4: in-range store at the top word of the window.
        EReq = 1'b1; EWrEn = 1'b1; EAddr = 32'h1FFC; EWrData = 32'hDEAD_BEEF; EByteEn = 4'b0011;
        @(negedge Clk);
        check("t4_egnt", 32'(EGnt), 32'h1);
        check("t4_memen", 32'({MemRdEn, MemWrEn}), 32'h1);
        check("t4_maddr", MemAddr, 32'h0FFC);
        check("t4_mwd", MemWrData, 32'hDEAD_BEEF);
        check("t4_mbe", 32'(MemByteEn), 32'h3);
        step();
        idle();
        @(negedge Clk);
        check("t4_no_rsp", 32'({ERdValid, EErr}), 32'h0);
        step();

        // Test 5: back-to-back core loads.
        CReq = 1'b1; CWrEn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            CAddr = 32'h1000 + 32'(k) * 32'd4;
            @(negedge Clk);
            check("t5_cgnt", 32'(CGnt), 32'h1);
            check("t5_maddr", MemAddr, 32'(k) * 32'd4);
            if (k > 0) check("t5_crdv", 32'(CRdValid), 32'h1);
            push(1'b0, CAddr);
            step();
        end
        idle();
        @(negedge Clk);
        check("t5_crdv_last", 32'(CRdValid), 32'h1);
        step();
        @(negedge Clk);
        check("t5_crdv_end", 32'(CRdValid), 32'h0);
        step();

        // Test 6: reset while a load is in flight, with the counter part way up.
        CReq = 1'b1; EReq = 1'b1; CWrEn = 1'b0; EWrEn = 1'b0;
        CAddr = 32'h1200; EAddr = 32'h1A00;
        @(negedge Clk);
        check("t6_cgnt0", 32'(CGnt), 32'h1);
        push(1'b0, CAddr);
        step();
        CAddr = 32'h1204;
        @(negedge Clk);
        check("t6_cgnt1", 32'(CGnt), 32'h1);
        step();
        Rst = 1'b1;
        CWrEn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk);
            check_all_zero("t6_rst");
            step();
        end
        Rst = 1'b0;
        CWrEn = 1'b0;
        begin
            int ci = 0;
            logic exp_e;
            for (int k = 0; k < 4; k++) begin
                CAddr = 32'h1300 + 32'(ci) * 32'd4;
                @(negedge Clk);
                exp_e = (k == 3);
                check("t6_cgnt", 32'(CGnt), 32'(!exp_e));
                check("t6_egnt", 32'(EGnt), 32'(exp_e));
                if (exp_e) begin
                    push(1'b1, EAddr);
                end else begin
                    push(1'b0, CAddr);
                    ci++;
                end
                step();
            end
        end
        idle();
        step();
        step();
        @(negedge Clk);
        check("sb_drain", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
